// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb
// sequencing over a single shared memory port.
module multicycle_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] instruction,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [2:0]       imm_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [2:0]       state_out
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [TW-1:0] tcnt;
  logic          retire;
  logic          set_ill;
  logic          set_berr;
  logic          tmo;

  logic [6:0] opcode;
  assign opcode = instruction[6:0];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi, is_op;
  logic legal;
  logic [2:0] fmt;

  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;
  assign is_br    = opcode == 7'b1100011;
  assign is_ld    = opcode == 7'b0000011;
  assign is_st    = opcode == 7'b0100011;
  assign is_opi   = opcode == 7'b0010011;
  assign is_op    = opcode == 7'b0110011;

  assign legal = (instruction[1:0] == 2'b11) &&
                 (is_lui | is_auipc | is_jal |
                  is_jalr | is_br | is_ld |
                  is_st | is_opi | is_op);

  always_comb begin
    fmt = 3'd0;
    unique case (1'b1)
      is_st:             fmt = 3'd1;
      is_br:             fmt = 3'd2;
      is_lui | is_auipc: fmt = 3'd3;
      is_jal:            fmt = 3'd4;
      default:           fmt = 3'd0;
    endcase
  end

  assign tmo = mem_req && !mem_ready &&
               (tcnt == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    imm_sel   = 3'd0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    halted    = 1'b0;
    if (rst_n) begin
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_DECODE: imm_sel = fmt;
        S_EXEC: begin
          imm_sel = fmt;
          unique case (1'b1)
            is_op: alu_op = 2'd2;
            is_opi: begin
              alu_src_b = 1'b1;
              alu_op    = 2'd2;
            end
            is_ld | is_st: alu_src_b = 1'b1;
            is_br: begin
              alu_op = 2'd1;
              pc_we  = 1'b1;
              pc_src = branch_taken ? 2'd1 : 2'd0;
            end
            is_auipc: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
            end
            is_jalr: alu_src_b = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          imm_sel  = fmt;
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = is_st;
          pc_we    = is_st && mem_ready;
        end
        S_WB: begin
          imm_sel = fmt;
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          unique case (1'b1)
            is_ld:  wb_sel = 2'd1;
            is_lui: wb_sel = 2'd3;
            is_jal: begin
              wb_sel = 2'd2;
              pc_src = 2'd1;
            end
            is_jalr: begin
              wb_sel = 2'd2;
              pc_src = 2'd2;
            end
            default: ;
          endcase
        end
        S_TRAP: halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt      = state;
    retire   = 1'b0;
    set_ill  = 1'b0;
    set_berr = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (mem_ready) nxt = S_DECODE;
        else if (tmo) begin
          nxt      = S_TRAP;
          set_berr = 1'b1;
        end
      end
      S_DECODE: begin
        if (legal) nxt = S_EXEC;
        else begin
          nxt     = S_TRAP;
          set_ill = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end else if (is_ld || is_st) nxt = S_MEM;
        else nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_st) begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end else nxt = S_WB;
        end else if (tmo) begin
          nxt      = S_TRAP;
          set_berr = 1'b1;
        end
      end
      S_WB: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
      retire_cnt <= '0;
      tcnt       <= '0;
    end else begin
      state <= nxt;
      if (set_ill) illegal <= 1'b1;
      if (set_berr) bus_err <= 1'b1;
      if (retire) retire_cnt <= retire_cnt + 1'b1;
      // wait counter restarts on any state change
      if (nxt != state || mem_ready || !mem_req)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl
// against a phase-list reference model.
module tb_multicycle_ctrl;

  localparam int CW  = 4;
  localparam int MOD = 16;
  localparam int TMO = 16;

  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_AUI = 7'h17;
  localparam logic [6:0] OP_JAL = 7'h6F;
  localparam logic [6:0] OP_JR  = 7'h67;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_OPI = 7'h13;
  localparam logic [6:0] OP_OP  = 7'h33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   instruction = '0;
  logic          branch_taken = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, addr_sel;
  logic          ir_we, pc_we;
  logic [1:0]    pc_src;
  logic [2:0]    imm_sel;
  logic          alu_src_a, alu_src_b;
  logic [1:0]    alu_op;
  logic          reg_we;
  logic [1:0]    wb_sel;
  logic          illegal, bus_err, halted;
  logic [CW-1:0] retire_cnt;
  logic [2:0]    state_out;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  logic [6:0] ops [9] = '{OP_LUI, OP_AUI, OP_JAL,
    OP_JR, OP_BR, OP_LD, OP_ST, OP_OPI, OP_OP};

  multicycle_ctrl #(
    .WIDTH(32), .MEM_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instruction(instruction),
    .branch_taken(branch_taken),
    .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src),
    .imm_sel(imm_sel),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel(wb_sel), .illegal(illegal),
    .bus_err(bus_err), .halted(halted),
    .retire_cnt(retire_cnt),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  logic [16:0] ctl;
  assign ctl = {mem_req, mem_we, addr_sel,
    ir_we, pc_we, pc_src, imm_sel, alu_src_a,
    alu_src_b, alu_op, reg_we, wb_sel};

  // Expected control vector per phase, straight from the control table
  function automatic logic [16:0] exp_ctl(
    input int ph, input logic [6:0] op,
    input logic rdy, input logic bt);
    logic mq, mw, as, iw, pw, sa, sb, rw;
    logic [1:0] ps, ao, ws;
    logic [2:0] is;
    {mq, mw, as, iw, pw, sa, sb, rw} = '0;
    ps = 0; ao = 0; ws = 0;
    case (op)
      OP_ST: is = 1;
      OP_BR: is = 2;
      OP_LUI, OP_AUI: is = 3;
      OP_JAL: is = 4;
      default: is = 0;
    endcase
    case (ph)
      0: begin mq = 1; iw = rdy; is = 0; end
      1: ;
      2: case (op)
        OP_OP: ao = 2;
        OP_OPI: begin sb = 1; ao = 2; end
        OP_LD, OP_ST, OP_JR: sb = 1;
        OP_AUI: begin sa = 1; sb = 1; end
        OP_BR: begin
          ao = 1; pw = 1; ps = bt ? 1 : 0;
        end
        default: ;
      endcase
      3: begin
        mq = 1; as = 1; mw = (op == OP_ST);
        pw = (op == OP_ST) && rdy;
      end
      4: begin
        rw = 1; pw = 1;
        case (op)
          OP_LD: ws = 1;
          OP_LUI: ws = 3;
          OP_JAL: begin ws = 2; ps = 1; end
          OP_JR: begin ws = 2; ps = 2; end
          default: ;
        endcase
      end
      default: is = 0;
    endcase
    if (ph == 5) is = 0;
    return {mq, mw, as, iw, pw, ps, is,
            sa, sb, ao, rw, ws};
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 8)];
    return r;
  endfunction

  // Tasks start and end just after a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic run_instr(input logic [31:0] ins,
    input logic bt, input int fw, input int mw);
    int ph_q[$];
    bit rd_q[$];
    logic [6:0] op;
    logic [16:0] e;
    op = ins[6:0];
    for (int i = 0; i <= fw; i++) begin
      ph_q.push_back(0); rd_q.push_back(i == fw);
    end
    ph_q.push_back(1); rd_q.push_back(0);
    ph_q.push_back(2); rd_q.push_back(0);
    if (op == OP_LD || op == OP_ST)
      for (int i = 0; i <= mw; i++) begin
        ph_q.push_back(3); rd_q.push_back(i == mw);
      end
    if (op != OP_BR && op != OP_ST) begin
      ph_q.push_back(4); rd_q.push_back(0);
    end
    foreach (ph_q[k]) begin
      instruction = ins;
      if (ph_q[k] == 0 || ph_q[k] == 3)
        mem_ready = rd_q[k];
      else
        mem_ready = 1'($urandom_range(0, 1));
      branch_taken = (ph_q[k] == 2) ? bt :
        1'($urandom_range(0, 1));
      #1;
      e = exp_ctl(ph_q[k], op, mem_ready,
                  branch_taken);
      checks++;
      if (state_out !== 3'(ph_q[k])) begin
        errors++;
        $display("FAIL state ins=%h cyc=%0d got=%0d exp=%0d",
          ins, k, state_out, ph_q[k]);
      end
      checks++;
      if (ctl !== e) begin
        errors++;
        $display("FAIL ctl ins=%h cyc=%0d got=%h exp=%h",
          ins, k, ctl, e);
      end
      checks++;
      if (retire_cnt !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL retire ins=%h got=%0d exp=%0d",
          ins, retire_cnt, exp_cnt);
      end
      checks++;
      if ({illegal, bus_err, halted} !== 3'b000) begin
        errors++;
        $display("FAIL flags ins=%h got=%b exp=000",
          ins, {illegal, bus_err, halted});
      end
      @(negedge clk);
      if (k == ph_q.size() - 1)
        exp_cnt = (exp_cnt + 1) % MOD;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instruction = 32'h00500093;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state_out !== 3'd0 || ctl !== '0 ||
        halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_out st=%0d ctl=%h h=%b exp 0",
        state_out, ctl, halted);
    end
    checks++;
    if ({illegal, bus_err} !== 2'b00 ||
        retire_cnt !== '0) begin
      errors++;
      $display("FAIL reset_regs got=%b/%0d exp=00/0",
        {illegal, bus_err}, retire_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_addi();
    run_instr(32'h00500093, 1'b0, 0, 0);
    checks++;
    if (retire_cnt !== 4'd1) begin
      errors++;
      $display("FAIL addi_retire got=%0d exp=1",
        retire_cnt);
    end
  endtask

  task automatic test_load();
    run_instr(32'h0000A103, 1'b0, 0, 3);
    checks++;
    if (retire_cnt !== 4'd2) begin
      errors++;
      $display("FAIL load_retire got=%0d exp=2",
        retire_cnt);
    end
  endtask

  task automatic test_branch();
    run_instr(32'h00000463, 1'b1, 0, 0);
    run_instr(32'h00000463, 1'b0, 1, 0);
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = 32'h0000007F;
    bad[1] = 32'h00500091;
    for (int n = 0; n < 2; n++) begin
      instruction = bad[n];
      mem_ready = 1'b1;
      #1;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state_out !== 3'd1 ||
          ctl !== exp_ctl(1, bad[n][6:0], 0, 0)) begin
        errors++;
        $display("FAIL ill_decode st=%0d ctl=%h exp 1/%h",
          state_out, ctl,
          exp_ctl(1, bad[n][6:0], 0, 0));
      end
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (state_out !== 3'd5 || ctl !== '0 ||
            {illegal, halted, bus_err} !== 3'b110) begin
          errors++;
          $display("FAIL ill_trap c=%0d st=%0d ctl=%h f=%b exp 5/0/110",
            c, state_out, ctl,
            {illegal, halted, bus_err});
        end
        @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      #1;
      checks++;
      if (state_out !== 3'd0 || illegal !== 1'b0 ||
          halted !== 1'b0 || retire_cnt !== '0) begin
        errors++;
        $display("FAIL ill_clear st=%0d i=%b h=%b r=%0d exp 0",
          state_out, illegal, halted, retire_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] sw;
    sw = 32'h0020A023;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      instruction = (m == 0) ? 32'h0000A103 : sw;
      if (m == 1) begin
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
      end
      for (int c = 0; c < TMO; c++) begin
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_out !== 3'(m * 3) ||
            mem_req !== 1'b1 || bus_err !== 1'b0) begin
          errors++;
          $display("FAIL tmo_wait m=%0d c=%0d st=%0d rq=%b be=%b",
            m, c, state_out, mem_req, bus_err);
        end
        @(negedge clk);
      end
      #1;
      checks++;
      if (state_out !== 3'd5 || bus_err !== 1'b1 ||
          halted !== 1'b1 || ctl !== '0) begin
        errors++;
        $display("FAIL tmo_trap m=%0d st=%0d be=%b h=%b exp 5/1/1",
          m, state_out, bus_err, halted);
      end
    end
    do_reset();
    run_instr(32'h0000A103, 1'b0, TMO - 1, TMO - 1);
    run_instr(sw, 1'b0, TMO - 1, TMO - 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_instr(rand_legal(),
        1'($urandom_range(0, 1)),
        $urandom_range(0, 3),
        $urandom_range(0, 3));
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 15; n++)
      run_instr(rand_legal(), 1'b0,
        $urandom_range(0, 1), $urandom_range(0, 1));
    checks++;
    if (retire_cnt !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre got=%0d exp=15",
        retire_cnt);
    end
    run_instr(32'h0080006F, 1'b0, 0, 0);
    checks++;
    if (retire_cnt !== 4'd0) begin
      errors++;
      $display("FAIL wrap got=%0d exp=0", retire_cnt);
    end
  endtask

  task automatic test_mid_reset();
    instruction = 32'h0000A103;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state_out !== 3'd3 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem st=%0d rq=%b exp 3/1",
        state_out, mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || ctl !== '0) begin
      errors++;
      $display("FAIL mid_drop rq=%b ctl=%h exp 0",
        mem_req, ctl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    #1;
    checks++;
    if (state_out !== 3'd0 || retire_cnt !== '0) begin
      errors++;
      $display("FAIL mid_state st=%0d r=%0d exp 0/0",
        state_out, retire_cnt);
    end
    run_instr(rand_legal(), 1'b1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_random();
    test_illegal();
    test_timeout();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core; sequences fetch, decode, execute, memory and writeback over one shared memory port.
- Drives PC/IR write enables, immediate-format select for the immediate generator, ALU operand/op selects, register writeback and memory handshake.
- Counts retired instructions.
- Traps on illegal opcode or memory timeout.

Parameters:
- WIDTH, 32, datapath/instruction width.
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before bus error (≥1).
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- instruction  in  WIDTH  current IR contents (opcode = [6:0]).
- branch_taken  in  1  branch comparator result, valid in EXEC.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a store.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_src  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result & ~1 (JALR).
- imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- alu_src_a  out  1  0 = rs1, 1 = PC.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  0 = add, 1 = branch compare, 2 = funct-decoded.
- reg_we  out  1  register file write enable.
- wb_sel  out  2  0 = ALU, 1 = mem data, 2 = PC+4, 3 = immediate.
- illegal  out  1  sticky illegal-opcode flag.
- bus_err  out  1  sticky memory-timeout flag.
- halted  out  1  FSM in TRAP.
- retire_cnt  out  CNT_W  retired-instruction count.
- state_out  out  3  current state encoding, debug.

Behaviour:
- States (state_out):
  - FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
  - Encodings 6–7 are unreachable; if entered, go to FETCH next cycle.
- All control outputs are combinational from state, opcode and mem_ready. Unasserted controls = 0.
- Reset (rst_n = 0 at posedge):
  - state = FETCH; illegal = bus_err = 0; retire_cnt = 0; timeout counter = 0.
  - Overrides any in-flight operation; a pending mem_req is simply dropped.
  - While rst_n is low, all combinational outputs = 0, including mem_req.
- FETCH:
  - mem_req = 1, addr_sel = 0, mem_we = 0.
  - On mem_ready: ir_we = 1 in the same cycle; next state DECODE.
- DECODE, 1 cycle:
  - imm_sel from opcode:
    - OP-IMM / LOAD / JALR → 0
    - STORE → 1
    - BRANCH → 2
    - LUI / AUIPC → 3
    - JAL → 4
    - R-type → 0 (don't-care)
  - Unknown opcode, or instruction[1:0] ≠ 2'b11: set illegal, next state TRAP. Otherwise next state EXEC.
- EXEC, 1 cycle; imm_sel held per opcode:
  - R-type: alu_src_b = 0, alu_op = 2.
  - OP-IMM: alu_src_b = 1, alu_op = 2.
  - LOAD / STORE: alu_src_b = 1, alu_op = 0; next state MEM.
  - BRANCH: alu_op = 1; pc_we = 1; pc_src = branch_taken ? 1 : 0; retire; next state FETCH.
  - AUIPC: alu_src_a = 1, alu_src_b = 1, alu_op = 0.
  - JALR: alu_src_b = 1, alu_op = 0.
  - All other opcodes: next state WB.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_we = (STORE).
  - On mem_ready: LOAD → WB; STORE → pc_we = 1, pc_src = 0, retire, next state FETCH.
- WB, 1 cycle: reg_we = 1, pc_we = 1.
  - LOAD: wb_sel = 1.
  - LUI: wb_sel = 3.
  - JAL: wb_sel = 2, pc_src = 1.
  - JALR: wb_sel = 2, pc_src = 2.
  - Others: wb_sel = 0, pc_src = 0.
  - Retire; next state FETCH.
- Retire: retire_cnt += 1 on the clock edge leaving the retiring state. Wraps 2^CNT_W−1 → 0.
- Timeout:
  - Counter clears on entry to FETCH/MEM and whenever mem_ready = 1.
  - Increments each cycle mem_req = 1 and mem_ready = 0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: set bus_err, next state TRAP.
  - mem_ready on the same cycle as the timeout wins; no error.
- mem_ready is ignored outside FETCH and MEM.
- TRAP: all controls 0, halted = 1, mem_req = 0. Only reset exits.
- Latency in cycles, zero-wait memory:
  - ALU / LUI / AUIPC / JAL / JALR = 4.
  - Branch = 3.
  - Store = 4.
  - Load = 5.

Test Plan:
1. Reset, then ADDI x1,x0,5 (0x00500093) with mem_ready always 1 → state sequence 0,1,2,4,0; reg_we only in WB, imm_sel = 0; retire_cnt = 1 after 4 cycles.
2. LW (0x0000A103) with mem_ready delayed 3 cycles in MEM → mem_req = 1, addr_sel = 1 for 4 cycles; WB wb_sel = 1; total 8 cycles; retire_cnt increments once.
3. BEQ (0x00000463), branch_taken = 1, then repeat with 0 → pc_we in EXEC with pc_src = 1 / 0 respectively; imm_sel = 2; no reg_we; 3 cycles each.
4. Opcode 0x7F in IR → DECODE→TRAP; illegal = 1, halted = 1, mem_req = 0 for 20 cycles; rst_n low one edge clears everything, state = 0.
5. mem_ready held 0 in FETCH, MEM_TIMEOUT = 16 → bus_err set after 16 waiting cycles, TRAP. Separate run: mem_ready on exactly the 16th cycle → no error, DECODE.
6. Preload retire_cnt near max (CNT_W = 4, 15 instructions), then JAL (0x0080006F) → wb_sel = 2, pc_src = 1, imm_sel = 4; retire_cnt wraps 15→0. Assert rst_n low mid-MEM → mem_req drops, state = FETCH next cycle.
